// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch controller: address width, branch op codes
// and the squash FSM state encoding.
package branch_ctrl_pkg;

    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        OP_JMP  = 3'd0,
        OP_BEQ  = 3'd1,
        OP_BNE  = 3'd2,
        OP_BLT  = 3'd3,
        OP_BGE  = 3'd4,
        OP_CALL = 3'd5,
        OP_RET  = 3'd6,
        OP_RSVD = 3'd7
    } br_op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SQUASH = 1'b1
    } squash_state_e;

endpackage

// File: rtl/branch_ctrl_ras_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest
// entry and the count saturates; a pop of an empty stack is ignored.
module ras_stack
    import branch_ctrl_pkg::*;
#(
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_data_i,
    output logic [ADDR_W-1:0] pop_data_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W:0]    count_q;
    logic [PTR_W-1:0]  top_idx;

    // ptr_q names the next free slot, so the newest entry sits one below it.
    assign top_idx    = ptr_q - PTR_W'(1);
    assign pop_data_o = mem[top_idx];
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (PTR_W+1)'(RAS_DEPTH));

    always_ff @(posedge clk) begin
        if (push_i && !reset) begin
            mem[ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else if (push_i) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (!full_o) begin
                count_q <= count_q + (PTR_W+1)'(1);
            end
        end else if (pop_i && !empty_o) begin
            ptr_q   <= top_idx;
            count_q <= count_q - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Resolves control-flow ops, emits a registered one-cycle redirect and squashes
// the SHADOW instructions that follow every taken redirect.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int SHADOW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_valid,
    input  logic [2:0]        br_op,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] cmp_a,
    input  logic [ADDR_W-1:0] cmp_b,
    output logic              branch_taken,
    output logic [ADDR_W-1:0] w_instruction_address,
    output logic              squash,
    output logic              ras_err
);

    localparam int CNT_W = (SHADOW < 2) ? 1 : $clog2(SHADOW + 1);

    br_op_e            op;
    logic              accept;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_full;

    squash_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              branch_taken_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ras_err_q;

    assign op       = br_op_e'(br_op);
    assign accept   = br_valid && !squash;
    assign ras_push = accept && (op == OP_CALL);
    assign ras_pop  = accept && (op == OP_RET) && !ras_empty;

    ras_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ras_stack (
        .clk         (clk),
        .reset       (reset),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (br_pc + ADDR_W'(1)),
        .pop_data_o  (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full)
    );

    always_comb begin
        taken  = 1'b0;
        target = br_target;
        case (op)
            OP_JMP, OP_CALL: taken = 1'b1;
            OP_BEQ:          taken = (cmp_a == cmp_b);
            OP_BNE:          taken = (cmp_a != cmp_b);
            OP_BLT:          taken = ($signed(cmp_a) <  $signed(cmp_b));
            OP_BGE:          taken = ($signed(cmp_a) >= $signed(cmp_b));
            OP_RET: begin
                taken  = 1'b1;
                target = ras_empty ? '0 : ras_top;
            end
            default:         taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_taken_q <= 1'b0;
            addr_q         <= '0;
            ras_err_q      <= 1'b0;
        end else begin
            branch_taken_q <= accept && taken;
            if (accept && taken) begin
                addr_q <= target;
            end
            if (accept && (op == OP_RET) && ras_empty) begin
                ras_err_q <= 1'b1;
            end
        end
    end

    // Squash FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Squash FSM: next state; the counter holds the squash cycles still to run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && taken && (SHADOW > 0)) begin
                    state_d = ST_SQUASH;
                    cnt_d   = CNT_W'(SHADOW);
                end
            end
            ST_SQUASH: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Squash FSM: outputs.
    always_comb begin
        squash = (state_q == ST_SQUASH);
    end

    assign branch_taken          = branch_taken_q;
    assign w_instruction_address = addr_q;
    assign ras_err               = ras_err_q;

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, range 2..16.
REQ-002 Parameter SHADOW, default 2: number of cycles squashed after a taken redirect.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 br_valid  in  1  a resolved control-flow instruction is presented this cycle.
REQ-006 br_op  in  3  0 JMP, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 CALL, 6 RET, 7 reserved (treated as not taken, no stack effect).
REQ-007 br_pc  in  16  address of the presented instruction.
REQ-008 br_target  in  16  absolute target address for JMP, BEQ, BNE, BLT, BGE and CALL.
REQ-009 cmp_a, cmp_b  in  16 each  compare operands.
REQ-010 branch_taken  out  1  registered one-cycle redirect pulse to the program counter.
REQ-011 w_instruction_address  out  16  registered redirect address; valid while branch_taken=1.
REQ-012 squash  out  1  current-cycle instruction must be discarded downstream.
REQ-013 ras_err  out  1  sticky flag: RET issued with an empty stack.

Function
REQ-014 An op is accepted when br_valid=1 and squash=0; br_valid is ignored while squash=1.
REQ-015 Taken conditions: JMP, CALL and RET always; BEQ a==b; BNE a!=b; BLT signed a<b; BGE signed a>=b.
REQ-016 An accepted taken op in cycle T drives branch_taken=1 for exactly cycle T+1, with w_instruction_address carrying the target.
REQ-017 The target is br_target for all taken ops except RET, whose target is the popped stack entry.
REQ-018 When an op is not taken, branch_taken stays 0; w_instruction_address holds its previous value.
REQ-019 CALL pushes br_pc+1, computed modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-020 RET pops the most recent entry.
REQ-021 RET with an empty stack: target 0x0000, ras_err set to 1, stack unchanged.
REQ-022 CALL with a full stack overwrites the oldest entry (circular buffer), and the count saturates at RAS_DEPTH.
REQ-023 FSM has two states, IDLE and SQUASH.
REQ-024 FSM transitions: an accepted taken op moves IDLE to SQUASH, with the counter loaded to SHADOW; SQUASH decrements each cycle and returns to IDLE when it reaches 0.
REQ-025 squash=1 exactly in the SHADOW cycles T+1 .. T+SHADOW following an accepted taken op in cycle T.
REQ-026 Ops presented while squash=1 have no stack effect, no redirect and no effect on ras_err.

Reset
REQ-027 While reset=1 at a clock edge:
- branch_taken=0, w_instruction_address=0x0000, squash=0, ras_err=0;
- FSM goes to IDLE, stack count=0, stack pointer=0.
REQ-028 Reset during SQUASH aborts the squash immediately; the first cycle after reset deasserts accepts ops.
REQ-029 Reset has priority over an op presented in the same cycle; that op is discarded.

Structure
REQ-030 Shared package holds the br_op encodings, the FSM state encoding and the address width constant (16).
REQ-031 The return stack is a sub-module named ras_stack, with push/pop/empty/full ports; branch_ctrl contains the compare logic, redirect register and squash FSM.

Verification
REQ-032 Conditional compares: BEQ a=5,b=5,target=0x0040 at T -> branch_taken=1, addr=0x0040 at T+1, squash high T+1..T+2; BNE with same operands -> no pulse, no squash.
REQ-033 Signed compare: BLT a=0xFFFF, b=0x0001 -> taken; BGE with same operands -> not taken.
REQ-034 Call/return: CALL at br_pc=0x0010 to 0x0100, then RET after the shadow -> RET redirects to 0x0011; CALL at br_pc=0xFFFF followed by RET -> 0x0000.
REQ-035 Stack overflow: 5 CALLs at br_pc=1..5 with RAS_DEPTH=4, then 5 RETs -> targets 6,5,4,3, then 0x0000 with ras_err=1.
REQ-036 Shadow masking: JMP to 0x0200 at T with a JMP to 0x0300 at T+1 and T+2 -> only the 0x0200 pulse appears; a JMP at T+3 is accepted.
REQ-037 Reset mid-SQUASH: reset at T+1 -> outputs zero next cycle; BEQ a=b presented the cycle after reset is accepted.
